// File: rtl/systolic_skew_feeder_if.sv
// Bundle of the operand-loader side and PE-array side signals of the skew feeder.
// The loader/controller drives through master; the feeder attaches as slave.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 16
);
    logic                           start;
    logic                           read_en;
    logic                           flush;
    logic [CHANNELS-1:0]            in_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] data_in;
    logic [CHANNELS*DATA_WIDTH-1:0] data_out;
    logic [CHANNELS-1:0]            out_valid;
    logic [CHANNELS-1:0]            full;
    logic [CHANNELS-1:0]            empty;
    logic [CHANNELS-1:0]            overflow;
    logic                           busy;
    logic                           done;

    modport master (
        output start, read_en, flush, in_valid, data_in,
        input  data_out, out_valid, full, empty, overflow, busy, done
    );

    modport slave (
        input  start, read_en, flush, in_valid, data_in,
        output data_out, out_valid, full, empty, overflow, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Per-channel circular operand buffers drained into the PE array edge with an
// optional diagonal skew: channel i's drain window opens i steps after channel 0.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 9,
    parameter int CHANNELS   = 16,
    parameter int SKEW_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_skew_feeder_if.slave sf
);
    localparam int L  = DEPTH + (CHANNELS - 1) * SKEW_EN;
    localparam int TW = $clog2(L);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {IDLE_ST = 1'b0, RUN_ST = 1'b1} state_t;

    state_t                         state_r;
    state_t                         state_s;
    logic [TW-1:0]                  t_r;
    logic [TW-1:0]                  t_s;
    logic                           step_s;
    logic                           last_step_s;
    logic                           busy_r;
    logic                           done_r;

    logic [DATA_WIDTH-1:0]          mem_r    [CHANNELS][DEPTH];
    logic [PW-1:0]                  wr_ptr_r [CHANNELS];
    logic [PW-1:0]                  rd_ptr_r [CHANNELS];
    logic [CW-1:0]                  count_r  [CHANNELS];
    logic [CHANNELS-1:0]            full_s;
    logic [CHANNELS-1:0]            empty_s;
    logic [CHANNELS-1:0]            wr_s;
    logic [CHANNELS-1:0]            pop_s;
    logic [CHANNELS-1:0]            ovf_set_s;
    logic [CHANNELS-1:0]            overflow_r;
    logic [CHANNELS-1:0]            out_valid_r;
    logic [CHANNELS*DATA_WIDTH-1:0] data_out_r;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Occupancy flags straight from the registered counts
    always_comb begin
        full_s  = {CHANNELS{1'b0}};
        empty_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            full_s[i]  = (count_r[i] == CW'(DEPTH));
            empty_s[i] = (count_r[i] == {CW{1'b0}});
        end
    end

    // Controller next state: one drain step per cycle while read_en is high in RUN
    always_comb begin
        state_s     = state_r;
        t_s         = t_r;
        step_s      = 1'b0;
        last_step_s = 1'b0;
        case (state_r)
            IDLE_ST: begin
                if (sf.start) begin
                    state_s = RUN_ST;
                    t_s     = {TW{1'b0}};
                end else begin
                    state_s = IDLE_ST;
                end
            end
            RUN_ST: begin
                if (sf.read_en) begin
                    step_s = 1'b1;
                    if (t_r == TW'(L - 1)) begin
                        last_step_s = 1'b1;
                        state_s     = IDLE_ST;
                        t_s         = {TW{1'b0}};
                    end else begin
                        t_s = t_r + TW'(1);
                    end
                end else begin
                    t_s = t_r;
                end
            end
            default: begin
                state_s = IDLE_ST;
                t_s     = {TW{1'b0}};
            end
        endcase
    end

    // Per-channel write/pop/overflow decisions; an empty channel in its window just pads
    always_comb begin
        wr_s      = {CHANNELS{1'b0}};
        pop_s     = {CHANNELS{1'b0}};
        ovf_set_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            wr_s[i]      = sf.in_valid[i] && !full_s[i];
            ovf_set_s[i] = sf.in_valid[i] && full_s[i];
            pop_s[i]     = step_s && !empty_s[i]
                           && (int'(t_r) >= i * SKEW_EN)
                           && (int'(t_r) <  i * SKEW_EN + DEPTH);
        end
    end

    // Buffer storage; contents need no clearing since pointers/counts define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!rst && !sf.flush && wr_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= sf.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointers, counts and sticky overflow per channel
    always_ff @(posedge clk) begin
        if (rst || sf.flush) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_r[i] <= {PW{1'b0}};
                rd_ptr_r[i] <= {PW{1'b0}};
                count_r[i]  <= {CW{1'b0}};
            end
            overflow_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_s[i]) begin
                    wr_ptr_r[i] <= ptr_next(wr_ptr_r[i]);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= ptr_next(rd_ptr_r[i]);
                end
                count_r[i] <= count_r[i] + CW'(wr_s[i]) - CW'(pop_s[i]);
                if (ovf_set_s[i]) begin
                    overflow_r[i] <= 1'b1;
                end
            end
        end
    end

    // Drain output register: zero padding on idle steps, held data during a stall
    always_ff @(posedge clk) begin
        if (rst || sf.flush) begin
            out_valid_r <= {CHANNELS{1'b0}};
            data_out_r  <= {(CHANNELS*DATA_WIDTH){1'b0}};
        end else if (step_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
                out_valid_r[i] <= pop_s[i];
                data_out_r[i*DATA_WIDTH +: DATA_WIDTH] <=
                    pop_s[i] ? mem_r[i][rd_ptr_r[i]] : {DATA_WIDTH{1'b0}};
            end
        end else if (state_r == RUN_ST) begin
            out_valid_r <= {CHANNELS{1'b0}};
        end else begin
            out_valid_r <= {CHANNELS{1'b0}};
            data_out_r  <= {(CHANNELS*DATA_WIDTH){1'b0}};
        end
    end

    // Controller state, step counter and status flags
    always_ff @(posedge clk) begin
        if (rst || sf.flush) begin
            state_r <= IDLE_ST;
            t_r     <= {TW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            t_r     <= t_s;
            busy_r  <= (state_s == RUN_ST);
            done_r  <= last_step_s;
        end
    end

    assign sf.data_out  = data_out_r;
    assign sf.out_valid = out_valid_r;
    assign sf.full      = full_s;
    assign sf.empty     = empty_s;
    assign sf.overflow  = overflow_r;
    assign sf.busy      = busy_r;
    assign sf.done      = done_r;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: DEPTH=4, CHANNELS=3 with a skewed and
// an unskewed instance sharing one stimulus stream.
module tb_systolic_skew_feeder;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CH = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   hold_data [CH];

    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) sf  ();
    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) sf0 ();

    assign sf0.start    = sf.start;
    assign sf0.read_en  = sf.read_en;
    assign sf0.flush    = sf.flush;
    assign sf0.in_valid = sf.in_valid;
    assign sf0.data_in  = sf.data_in;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .DEPTH(DP), .CHANNELS(CH), .SKEW_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .sf  (sf)
    );

    systolic_skew_feeder #(.DATA_WIDTH(DW), .DEPTH(DP), .CHANNELS(CH), .SKEW_EN(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .sf  (sf0)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // channel i receives 10*i + {1,2,3,4}
    task automatic load_all();
        for (int k = 0; k < DP; k++) begin
            sf.in_valid = 3'b111;
            sf.data_in  = {8'(20 + k + 1), 8'(10 + k + 1), 8'(k + 1)};
            tick();
        end
        sf.in_valid = 3'b000;
        sf.data_in  = 24'd0;
    endtask

    function automatic int skew_data(int ch, int s);
        int k;
        k = s - ch;
        if (k >= 0 && k < DP) return 10 * ch + k + 1;
        return 0;
    endfunction

    task automatic check_idle_state(input string tag);
        check_val({tag, " data_out"},  sf.data_out,  0);
        check_val({tag, " out_valid"}, sf.out_valid, 0);
        check_val({tag, " busy"},      sf.busy,      0);
        check_val({tag, " done"},      sf.done,      0);
        check_val({tag, " overflow"},  sf.overflow,  0);
        check_val({tag, " full"},      sf.full,      0);
        check_val({tag, " empty"},     sf.empty,     3'b111);
    endtask

    // prev step of -2 = no step (idle), -1 = stalled step
    task automatic run_skew(input bit stalled);
        int last;
        int prev;
        int ed;
        last = stalled ? 8 : 6;
        for (int i = 0; i < CH; i++) hold_data[i] = 0;
        load_all();
        sf.read_en = 1'b1;
        sf.start   = 1'b1;
        tick();
        sf.start = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            if (stalled) begin
                case (c)
                    2: prev = 0;
                    3: prev = 1;
                    4, 5: prev = -1;
                    6: prev = 2;
                    7: prev = 3;
                    8: prev = 4;
                    9: prev = 5;
                    default: prev = -2;
                endcase
            end else begin
                prev = (c >= 2) ? c - 2 : -2;
            end
            sf.read_en = stalled ? !(c == 3 || c == 4) : 1'b1;
            for (int i = 0; i < CH; i++) begin
                if (prev == -1) begin
                    ed = hold_data[i];
                    check_val($sformatf("s%0d c%0d ov%0d", stalled, c, i), sf.out_valid[i], 0);
                end else begin
                    ed = (prev == -2) ? 0 : skew_data(i, prev);
                    hold_data[i] = ed;
                    check_val($sformatf("s%0d c%0d ov%0d", stalled, c, i), sf.out_valid[i], (ed != 0));
                end
                check_val($sformatf("s%0d c%0d d%0d", stalled, c, i), sf.data_out[i*DW +: DW], ed);
                if (!stalled) begin
                    check_val($sformatf("noskew c%0d ov%0d", c, i), sf0.out_valid[i], (c >= 2 && c <= 5));
                    check_val($sformatf("noskew c%0d d%0d", c, i), sf0.data_out[i*DW +: DW],
                              (c >= 2 && c <= 5) ? 10 * i + c - 1 : 0);
                end
            end
            check_val($sformatf("s%0d c%0d busy", stalled, c), sf.busy, (c <= last));
            check_val($sformatf("s%0d c%0d done", stalled, c), sf.done, (c == last + 1));
            if (!stalled) begin
                check_val($sformatf("noskew c%0d busy", c), sf0.busy, (c <= 4));
                check_val($sformatf("noskew c%0d done", c), sf0.done, (c == 5));
            end
            tick();
        end
    endtask

    // Abort a run at cycle 3 with rst (use_flush=0) or flush (use_flush=1)
    task automatic abort_run(input bit use_flush);
        string tag;
        tag = use_flush ? "flush" : "rst";
        load_all();
        sf.read_en = 1'b1;
        sf.start   = 1'b1;
        tick();
        sf.start = 1'b0;
        tick();
        tick();
        if (use_flush) sf.flush = 1'b1;
        else           rst      = 1'b1;
        tick();
        sf.flush = 1'b0;
        rst      = 1'b0;
        check_idle_state({tag, " c4"});
        sf.start = 1'b1;
        tick();
        sf.start = 1'b0;
        check_val({tag, " c5 busy"}, sf.busy, 1);
        check_val({tag, " c5 done"}, sf.done, 0);
        sf.flush = 1'b1;
        tick();
        sf.flush = 1'b0;
        check_val({tag, " end busy"}, sf.busy, 0);
        check_val({tag, " end done"}, sf.done, 0);
    endtask

    initial begin
        rst         = 1'b1;
        sf.start    = 1'b0;
        sf.read_en  = 1'b0;
        sf.flush    = 1'b0;
        sf.in_valid = 3'b000;
        sf.data_in  = 24'd0;
        tick();
        tick();
        check_idle_state("reset");
        rst = 1'b0;
        tick();

        run_skew(1'b0);
        run_skew(1'b1);

        // Overflow on ch1
        for (int k = 1; k <= 5; k++) begin
            sf.in_valid = 3'b010;
            sf.data_in  = {8'd0, 8'(k), 8'd0};
            tick();
            if (k == 3) check_val("ovf full after 3", sf.full[1], 0);
            if (k == 4) check_val("ovf full after 4", sf.full[1], 1);
            if (k == 4) check_val("ovf flag after 4", sf.overflow[1], 0);
            if (k == 5) check_val("ovf flag after 5", sf.overflow, 3'b010);
        end
        sf.in_valid = 3'b000;
        sf.read_en  = 1'b1;
        sf.start    = 1'b1;
        tick();
        sf.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check_val($sformatf("ovf c%0d ov", c), sf.out_valid, (c >= 3 && c <= 6) ? 3'b010 : 3'b000);
            check_val($sformatf("ovf c%0d d1", c), sf.data_out[DW +: DW], (c >= 3 && c <= 6) ? c - 2 : 0);
            check_val($sformatf("ovf c%0d done", c), sf.done, (c == 7));
            tick();
        end
        check_val("ovf sticky", sf.overflow, 3'b010);
        sf.flush = 1'b1;
        tick();
        sf.flush = 1'b0;
        check_val("flush overflow", sf.overflow, 0);
        check_val("flush empty", sf.empty, 3'b111);

        // Underrun with concurrent write on ch0
        for (int k = 7; k <= 8; k++) begin
            sf.in_valid = 3'b001;
            sf.data_in  = {16'd0, 8'(k)};
            tick();
        end
        sf.in_valid = 3'b000;
        sf.start    = 1'b1;
        tick();
        sf.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            sf.in_valid = (c == 2) ? 3'b001 : 3'b000;
            sf.data_in  = (c == 2) ? 24'd9 : 24'd0;
            check_val($sformatf("udr c%0d ov", c), sf.out_valid, (c >= 2 && c <= 4) ? 3'b001 : 3'b000);
            check_val($sformatf("udr c%0d d0", c), sf.data_out[0 +: DW],
                      (c == 2) ? 7 : (c == 3) ? 8 : (c == 4) ? 9 : 0);
            check_val($sformatf("udr c%0d full0", c), sf.full[0], 0);
            check_val($sformatf("udr c%0d empty0", c), sf.empty[0], (c >= 4));
            check_val($sformatf("udr c%0d done", c), sf.done, (c == 7));
            tick();
        end
        sf.in_valid = 3'b000;
        sf.data_in  = 24'd0;

        abort_run(1'b0);
        abort_run(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Per-channel buffer bank that loads operand streams independently, then drains them into the systolic array edge with a diagonal skew: channel i starts i steps after channel 0. It is the parametrised successor of the plain per-channel shift-register bank. It adds FIFO occupancy tracking, overflow detection, a start/stall/flush controller and an optional skew mode. It sits between the operand loaders and the row or column inputs of the PE array.

## Interface
- DATA_WIDTH, 8, bits per element
- DEPTH, 9, entries per channel buffer (>=2)
- CHANNELS, 16, number of independent channels (>=1)
- SKEW_EN, 1, 1 = channel i drain delayed by i steps; 0 = all channels drain together
- clk  in  1  clock; everything on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a drain run; honoured only in IDLE
- read_en  in  1  drain advance enable; low during RUN = stall
- flush  in  1  synchronous clear of all buffers and controller
- in_valid  in  CHANNELS  per-channel write strobe
- data_in  in  CHANNELS*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- data_out  out  CHANNELS*DATA_WIDTH  registered drain data, same packing
- out_valid  out  CHANNELS  registered; data_out slice i valid this cycle
- full  out  CHANNELS  count==DEPTH
- empty  out  CHANNELS  count==0
- overflow  out  CHANNELS  sticky; write attempted while full
- busy  out  1  controller in RUN
- done  out  1  one-cycle pulse at end of run

## Operation
- Each channel is a circular buffer of DEPTH entries with wr_ptr, rd_ptr and count. Count is $clog2(DEPTH+1) bits wide. Pointers wrap from DEPTH-1 to 0.
- Write: in_valid[i] && !full[i] stores data_in slice i. Writes are accepted in any state.
- in_valid[i] && full[i]: the data is dropped and overflow[i] is set. overflow[i] clears only on rst or flush.
- Controller FSM has two states, IDLE and RUN. It uses a step counter t of $clog2(L) bits, where L = DEPTH + (CHANNELS-1)*SKEW_EN.
- IDLE -> RUN on start. t is reset to 0. start is ignored in RUN.
- In RUN, while read_en is high:
  - Channel i pops iff i*SKEW_EN <= t < i*SKEW_EN + DEPTH and !empty[i].
  - Then t increments.
  - RUN -> IDLE after the step with t == L-1.
- In RUN with read_en low: t holds, no pops, data_out holds, out_valid all 0.
- Pop is registered. Popped entry goes to data_out slice i and out_valid[i]=1 next cycle. A channel with no pop that step: out_valid[i]=0 and data_out slice i is forced to 0, so the PE array sees zero padding.
- Pop of an empty channel inside its window is not an error. It produces zero padding (underrun is tolerated).
- Write and pop on the same channel in the same cycle: both happen and count is unchanged. There is no bypass: a write to an empty channel cannot be popped in the same cycle.
- Priority: rst > flush > normal operation.
- flush in any state:
  - Pointers and counts go to 0 and overflow goes to 0.
  - State goes to IDLE.
  - out_valid goes to 0 and data_out to 0.
  - No done pulse.
  - Any in_valid in the flush cycle is discarded.

## Timing
- Reset values: data_out=0, out_valid=0, busy=0, done=0, overflow=0, full=0, empty=all 1, state IDLE, t=0.
- Cycle 0: start high in IDLE. Cycle 1: busy=1, step t=0 executes.
- Pop at step t (cycle c) appears on data_out/out_valid at cycle c+1.
- Without stalls, channel i's first output is at cycle 2+i*SKEW_EN.
- The last step executes at cycle L. At cycle L+1: busy=0, done=1 for exactly one cycle, and the last pop is visible.
- A start at cycle L+1 is accepted: busy is 0 and the state is IDLE.
- Each stall cycle extends the run and the done cycle by exactly one.
- full, empty and count update the cycle after the write or pop edge. full and empty are combinational from the registered count.
- Mid-run rst or flush: the next cycle is IDLE, busy=0, done=0 and all buffers are empty.

## Test plan
- Bench uses DATA_WIDTH=8, DEPTH=4, CHANNELS=3, SKEW_EN=1, so L=6.
- Basic skewed drain:
  - Stimulus: load channel i with 10*i+{1,2,3,4}, then start with read_en held high.
  - Required: ch0 outputs 1,2,3,4 at cycles 2..5. ch1 outputs 11..14 at cycles 3..6. ch2 outputs 21..24 at cycles 4..7.
  - Required: zeros with out_valid=0 elsewhere; done at cycle 7; busy high cycles 1..6.
- SKEW_EN=0 variant:
  - Stimulus: same load and start.
  - Required: all channels valid at cycles 2..5, done at cycle 5.
- Overflow:
  - Stimulus: write 5 values 1..5 to ch1.
  - Required: full[1]=1 after the 4th write, overflow[1]=1 after the 5th. The drain yields 1,2,3,4.
  - Stimulus: flush.
  - Required: overflow[1]=0, empty=3'b111.
- Stall:
  - Stimulus: the basic run with read_en low at cycles 3 and 4.
  - Required: out_valid=0 and data_out held at cycles 4 and 5; sequence order unchanged; done moves to cycle 9.
- Underrun and concurrent write:
  - Stimulus: ch0 holds 2 entries (7,8); start; write 9 to ch0 at cycle 2 while it pops.
  - Required: ch0 outputs 7,8,9 then zero padding at cycle 5; count never exceeds 2.
- Reset and flush mid-run:
  - Stimulus: rst at cycle 3 of a run.
  - Required: next cycle all outputs at reset values and start accepted.
  - Stimulus: repeat with flush.
  - Required: same result, no done pulse.
